// File: rtl/insn_fetch.sv
// Opcode supply for the decoder: loads the reset vector, fetches opcode bytes at PC,
// injects BRK for pending NMI/IRQ and owns the program counter.
module insn_fetch #(
    parameter int unsigned        ADDR_W    = 16,
    parameter logic [ADDR_W-1:0]  RESET_VEC = 16'hFFFC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              nmi,
    input  logic              irq,
    input  logic              irq_mask,
    input  logic [7:0]        data_in,
    output logic [ADDR_W-1:0] addr,
    output logic              rd_en,
    output logic [7:0]        insn,
    output logic              insn_valid,
    input  logic              insn_ack,
    input  logic [1:0]        insn_len,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    output logic [1:0]        int_kind,
    output logic [ADDR_W-1:0] pc
);

    typedef enum logic [2:0] {
        StVlo,
        StVhi,
        StVld,
        StFetch,
        StCapt,
        StHold
    } state_e;

    localparam logic [1:0] KindNormal = 2'b00;
    localparam logic [1:0] KindIrq    = 2'b01;
    localparam logic [1:0] KindNmi    = 2'b10;

    localparam logic [ADDR_W-1:0] ResetVecHi = RESET_VEC + ADDR_W'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        insn_q, insn_d;
    logic [1:0]        kind_q, kind_d;
    logic              nmi_q;
    logic              nmi_pend_q, nmi_pend_d;
    logic              nmi_edge;
    logic [1:0]        len_eff;

    assign nmi_edge = nmi & ~nmi_q;
    assign len_eff  = (insn_len == 2'd0) ? 2'd1 : insn_len;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        insn_d     = insn_q;
        kind_d     = kind_q;
        nmi_pend_d = nmi_pend_q;
        addr       = pc_q;
        rd_en      = 1'b0;

        unique case (state_q)
            StVlo: begin
                addr  = RESET_VEC;
                rd_en = 1'b1;
                if (rdy) state_d = StVhi;
            end
            StVhi: begin
                addr  = ResetVecHi;
                rd_en = 1'b1;
                if (rdy) begin
                    pc_d[7:0] = data_in;
                    state_d   = StVld;
                end
            end
            StVld: begin
                addr = ResetVecHi;
                if (rdy) begin
                    pc_d[15:8] = data_in;
                    state_d    = StFetch;
                end
            end
            StFetch: begin
                if (pc_load) begin
                    // Redirect before any read so the stale PC is never fetched.
                    pc_d = pc_load_val;
                end else if (nmi_pend_q) begin
                    if (rdy) begin
                        insn_d     = 8'h00;
                        kind_d     = KindNmi;
                        nmi_pend_d = 1'b0;
                        state_d    = StHold;
                    end
                end else if (irq && !irq_mask) begin
                    if (rdy) begin
                        insn_d  = 8'h00;
                        kind_d  = KindIrq;
                        state_d = StHold;
                    end
                end else begin
                    rd_en = 1'b1;
                    if (rdy) state_d = StCapt;
                end
            end
            StCapt: begin
                if (pc_load) begin
                    pc_d    = pc_load_val;
                    state_d = StFetch;
                end else if (rdy) begin
                    insn_d  = data_in;
                    kind_d  = KindNormal;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (pc_load) begin
                    pc_d    = pc_load_val;
                    state_d = StFetch;
                end else if (insn_ack) begin
                    // Injected BRK leaves PC on the interrupted instruction.
                    if (kind_q == KindNormal) pc_d = pc_q + ADDR_W'(len_eff);
                    state_d = StFetch;
                end
            end
            default: state_d = StVlo;
        endcase

        // A new edge wins over a same-cycle service.
        if (nmi_edge) nmi_pend_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StVlo;
            pc_q       <= '0;
            insn_q     <= 8'h00;
            kind_q     <= KindNormal;
            nmi_q      <= 1'b0;
            nmi_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            insn_q     <= insn_d;
            kind_q     <= kind_d;
            nmi_q      <= nmi;
            nmi_pend_q <= nmi_pend_d;
        end
    end

    assign insn       = insn_q;
    assign int_kind   = kind_q;
    assign pc         = pc_q;
    assign insn_valid = (state_q == StHold);

endmodule

// File: tb/tb_insn_fetch.sv
// Directed bench for insn_fetch: a byte memory model answers reads one cycle later,
// and each scenario task checks outputs 1 time unit after the rising edge.
module tb_insn_fetch;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        nmi;
    logic        irq;
    logic        irq_mask;
    logic [7:0]  data_in;
    logic [15:0] addr;
    logic        rd_en;
    logic [7:0]  insn;
    logic        insn_valid;
    logic        insn_ack;
    logic [1:0]  insn_len;
    logic        pc_load;
    logic [15:0] pc_load_val;
    logic [1:0]  int_kind;
    logic [15:0] pc;

    logic [7:0]  mem [0:65535];
    int          n_checks;
    int          n_fail;

    insn_fetch #(
        .ADDR_W    (16),
        .RESET_VEC (16'hFFFC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .nmi         (nmi),
        .irq         (irq),
        .irq_mask    (irq_mask),
        .data_in     (data_in),
        .addr        (addr),
        .rd_en       (rd_en),
        .insn        (insn),
        .insn_valid  (insn_valid),
        .insn_ack    (insn_ack),
        .insn_len    (insn_len),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .int_kind    (int_kind),
        .pc          (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en && rdy) data_in <= mem[addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL rst_pc: got %h want 0000", pc); end
        n_checks++; if (insn !== 8'h00) begin n_fail++; $display("FAIL rst_insn: got %h want 00", insn); end
        n_checks++; if (insn_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", insn_valid); end
        n_checks++; if (int_kind !== 2'b00) begin n_fail++; $display("FAIL rst_kind: got %b want 00", int_kind); end
        n_checks++; if (addr !== 16'hFFFC || rd_en !== 1'b1) begin
            n_fail++; $display("FAIL rst_vlo_bus: addr=%h rd_en=%b want FFFC/1", addr, rd_en);
        end
        rst = 1'b0;
    endtask

    task automatic test_vector();
        tick();
        n_checks++; if (addr !== 16'hFFFD || rd_en !== 1'b1) begin
            n_fail++; $display("FAIL vec_vhi_bus: addr=%h rd_en=%b want FFFD/1", addr, rd_en);
        end
        tick();
        n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL vec_vld_rd: got %b want 0", rd_en); end
        tick();
        n_checks++; if (pc !== 16'h1234) begin n_fail++; $display("FAIL vec_pc: got %h want 1234", pc); end
        n_checks++; if (addr !== 16'h1234 || rd_en !== 1'b1) begin
            n_fail++; $display("FAIL vec_fetch_bus: addr=%h rd_en=%b want 1234/1", addr, rd_en);
        end
        tick();
        n_checks++; if (insn_valid !== 1'b0) begin n_fail++; $display("FAIL vec_capt_valid: got %b want 0", insn_valid); end
        tick();
        n_checks++; if (insn_valid !== 1'b1 || insn !== 8'hA9) begin
            n_fail++; $display("FAIL vec_first_insn: valid=%b insn=%h want 1/A9", insn_valid, insn);
        end
        n_checks++; if (int_kind !== 2'b00) begin n_fail++; $display("FAIL vec_kind: got %b want 00", int_kind); end
    endtask

    task automatic test_advance();
        insn_ack = 1'b1; insn_len = 2'd2;
        tick();
        insn_ack = 1'b0;
        n_checks++; if (addr !== 16'h1236 || insn_valid !== 1'b0) begin
            n_fail++; $display("FAIL adv_len2: addr=%h valid=%b want 1236/0", addr, insn_valid);
        end
        tick(); tick();
        n_checks++; if (insn !== 8'h85) begin n_fail++; $display("FAIL adv_insn: got %h want 85", insn); end
        pc_load = 1'b1; pc_load_val = 16'hFFFF;
        tick();
        pc_load = 1'b0;
        n_checks++; if (pc !== 16'hFFFF) begin n_fail++; $display("FAIL adv_load: got %h want FFFF", pc); end
        tick(); tick();
        n_checks++; if (insn !== 8'h4C) begin n_fail++; $display("FAIL adv_ffff_insn: got %h want 4C", insn); end
        insn_ack = 1'b1; insn_len = 2'd1;
        tick();
        insn_ack = 1'b0;
        n_checks++; if (addr !== 16'h0000 || pc !== 16'h0000) begin
            n_fail++; $display("FAIL adv_wrap: addr=%h pc=%h want 0000", addr, pc);
        end
        tick(); tick();
        n_checks++; if (insn !== 8'hE8) begin n_fail++; $display("FAIL adv_0000_insn: got %h want E8", insn); end
        insn_ack = 1'b1; insn_len = 2'd0;
        tick();
        insn_ack = 1'b0; insn_len = 2'd1;
        n_checks++; if (pc !== 16'h0001) begin n_fail++; $display("FAIL adv_len0: got %h want 0001", pc); end
        tick(); tick();
        n_checks++; if (insn !== 8'hCA) begin n_fail++; $display("FAIL adv_0001_insn: got %h want CA", insn); end
    endtask

    task automatic test_irq();
        irq = 1'b1; irq_mask = 1'b0;
        insn_ack = 1'b1; insn_len = 2'd1;
        tick();
        insn_ack = 1'b0;
        n_checks++; if (pc !== 16'h0002 || rd_en !== 1'b0) begin
            n_fail++; $display("FAIL irq_fetch: pc=%h rd_en=%b want 0002/0", pc, rd_en);
        end
        tick();
        n_checks++; if (insn_valid !== 1'b1 || insn !== 8'h00 || int_kind !== 2'b01) begin
            n_fail++;
            $display("FAIL irq_brk: valid=%b insn=%h kind=%b want 1/00/01", insn_valid, insn, int_kind);
        end
        insn_ack = 1'b1; insn_len = 2'd3; irq = 1'b0;
        tick();
        insn_ack = 1'b0; insn_len = 2'd1;
        n_checks++; if (pc !== 16'h0002) begin n_fail++; $display("FAIL irq_no_adv: got %h want 0002", pc); end
        irq = 1'b1; irq_mask = 1'b1;
        tick(); tick();
        n_checks++; if (insn !== 8'hE6 || int_kind !== 2'b00) begin
            n_fail++; $display("FAIL irq_masked: insn=%h kind=%b want E6/00", insn, int_kind);
        end
    endtask

    task automatic test_nmi_priority();
        irq_mask = 1'b0;
        nmi = 1'b1; insn_ack = 1'b1;
        tick();
        nmi = 1'b0; insn_ack = 1'b0;
        tick();
        n_checks++; if (int_kind !== 2'b10 || insn !== 8'h00 || pc !== 16'h0003) begin
            n_fail++; $display("FAIL nmi_first: kind=%b insn=%h pc=%h want 10/00/0003", int_kind, insn, pc);
        end
        insn_ack = 1'b1;
        tick();
        insn_ack = 1'b0;
        tick();
        n_checks++; if (int_kind !== 2'b01) begin n_fail++; $display("FAIL nmi_then_irq: got %b want 01", int_kind); end
        irq = 1'b0; insn_ack = 1'b1;
        tick();
        insn_ack = 1'b0;
        tick(); tick();
        n_checks++; if (int_kind !== 2'b00 || insn !== 8'hEA || pc !== 16'h0003) begin
            n_fail++; $display("FAIL nmi_once: kind=%b insn=%h pc=%h want 00/EA/0003", int_kind, insn, pc);
        end
    endtask

    task automatic test_nmi_hold();
        nmi = 1'b1;
        tick();
        nmi = 1'b0;
        tick(); tick();
        n_checks++; if (insn_valid !== 1'b1 || insn !== 8'hEA) begin
            n_fail++; $display("FAIL nmih_hold: valid=%b insn=%h want 1/EA", insn_valid, insn);
        end
        insn_ack = 1'b1;
        tick();
        insn_ack = 1'b0;
        tick();
        n_checks++; if (int_kind !== 2'b10 || pc !== 16'h0004) begin
            n_fail++; $display("FAIL nmih_brk: kind=%b pc=%h want 10/0004", int_kind, pc);
        end
        insn_ack = 1'b1;
        tick();
        insn_ack = 1'b0;
        tick();
        n_checks++; if (insn_valid !== 1'b0) begin n_fail++; $display("FAIL nmih_capt: got %b want 0", insn_valid); end
        tick();
        n_checks++; if (int_kind !== 2'b00) begin n_fail++; $display("FAIL nmih_once: got %b want 00", int_kind); end
    endtask

    task automatic test_rdy_stall();
        insn_ack = 1'b1;
        tick();
        insn_ack = 1'b0;
        tick();
        rdy = 1'b0; insn_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (insn_valid !== 1'b0 || addr !== 16'h0005 || rd_en !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_%0d: valid=%b addr=%h rd_en=%b want 0/0005/0", i, insn_valid, addr, rd_en);
            end
        end
        rdy = 1'b1; insn_ack = 1'b0;
        tick();
        n_checks++; if (insn_valid !== 1'b1 || insn !== 8'h9D || pc !== 16'h0005) begin
            n_fail++; $display("FAIL stall_done: valid=%b insn=%h pc=%h want 1/9D/0005", insn_valid, insn, pc);
        end
    endtask

    task automatic test_flush();
        pc_load = 1'b1; pc_load_val = 16'h8000; insn_ack = 1'b1; insn_len = 2'd2;
        tick();
        pc_load = 1'b0; insn_ack = 1'b0; insn_len = 2'd1;
        n_checks++; if (insn_valid !== 1'b0 || pc !== 16'h8000 || addr !== 16'h8000) begin
            n_fail++; $display("FAIL flush: valid=%b pc=%h addr=%h want 0/8000/8000", insn_valid, pc, addr);
        end
        tick(); tick();
        n_checks++; if (insn !== 8'h20 || insn_valid !== 1'b1) begin
            n_fail++; $display("FAIL flush_insn: insn=%h valid=%b want 20/1", insn, insn_valid);
        end
    endtask

    task automatic test_reset_mid();
        insn_ack = 1'b1;
        tick();
        insn_ack = 1'b0; nmi = 1'b1;
        tick();
        rst = 1'b1; nmi = 1'b0;
        tick();
        rst = 1'b0;
        n_checks++; if (addr !== 16'hFFFC || rd_en !== 1'b1 || pc !== 16'h0000 || insn !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_rst: addr=%h rd_en=%b pc=%h insn=%h want FFFC/1/0000/00", addr, rd_en, pc, insn);
        end
        tick(); tick(); tick();
        n_checks++; if (pc !== 16'h1234 || rd_en !== 1'b1) begin
            n_fail++; $display("FAIL mid_refetch: pc=%h rd_en=%b want 1234/1", pc, rd_en);
        end
        tick(); tick();
        n_checks++; if (insn !== 8'hA9 || int_kind !== 2'b00) begin
            n_fail++; $display("FAIL mid_nmi_dropped: insn=%h kind=%b want A9/00", insn, int_kind);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
        mem[16'hFFFC] = 8'h34;
        mem[16'hFFFD] = 8'h12;
        mem[16'h1234] = 8'hA9;
        mem[16'h1236] = 8'h85;
        mem[16'hFFFF] = 8'h4C;
        mem[16'h0000] = 8'hE8;
        mem[16'h0001] = 8'hCA;
        mem[16'h0002] = 8'hE6;
        mem[16'h0005] = 8'h9D;
        mem[16'h8000] = 8'h20;
        data_in     = 8'h00;
        rst         = 1'b1;
        rdy         = 1'b1;
        nmi         = 1'b0;
        irq         = 1'b0;
        irq_mask    = 1'b1;
        insn_ack    = 1'b0;
        insn_len    = 2'd1;
        pc_load     = 1'b0;
        pc_load_val = 16'h0000;

        test_reset();
        test_vector();
        test_advance();
        test_irq();
        test_nmi_priority();
        test_nmi_hold();
        test_rdy_stall();
        test_flush();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
